pi_cfg_writer: RTL and testbench

//  On-FPGA initiator for the config-register write path: queues (addr,data) requests and drives PiBus

---
 rtl/pi_pkg.sv | 29 ++
 rtl/pi_cfg_writer_if.sv | 36 +++
 rtl/cfg_req_fifo.sv | 58 +++++
 rtl/pi_cfg_writer.sv | 154 +++++++++++++++
 tb/tb_pi_cfg_writer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pi_pkg
//  Description : Shared types for the PiBus config-register write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pi_pkg;

    localparam int CFG_REGS = 16;
    localparam int CFG_AW   = $clog2(CFG_REGS);

    // One queued config write: target register index and value.
    typedef struct packed {
        logic [CFG_AW-1:0] addr;
        logic [7:0]        data;
    } cfg_req_t;

    typedef enum logic [2:0] {
        CW_IDLE   = 3'd0,
        CW_WRITE  = 3'd1,
        CW_SETTLE = 3'd2,
        CW_VERIFY = 3'd3,
        CW_DONE   = 3'd4,
        CW_ERR    = 3'd5
    } cw_state_t;

endpackage
`default_nettype wire

// File: rtl/pi_cfg_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pi_cfg_writer_if
//  Description : Request handshake plus PiBus write/readback signals of the
//                config writer. The writer is the PiBus master; the slave
//                side is the request source together with the cfg file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pi_cfg_writer_if;
    import pi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [CFG_AW-1:0] req_addr;
    logic [7:0]        req_data;

    logic              pi_act;
    logic              pi_we;
    logic              pi_ce_cfg;
    logic [CFG_AW-1:0] pi_addr;
    logic [7:0]        pi_dato;
    logic [7:0]        pi_di;

    modport master (
        input  req_valid, req_addr, req_data, pi_di,
        output req_ready, pi_act, pi_we, pi_ce_cfg, pi_addr, pi_dato
    );

    modport slave (
        output req_valid, req_addr, req_data, pi_di,
        input  req_ready, pi_act, pi_we, pi_ce_cfg, pi_addr, pi_dato
    );

endinterface
`default_nettype wire

// File: rtl/cfg_req_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cfg_req_fifo
//  Description : Small synchronous FIFO of cfg_req_t. Pointers carry one extra
//                wrap bit so full and empty are told apart without a counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_req_fifo
    import pi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     push,
    input  wire cfg_req_t push_data,
    input  wire logic     pop,
    output cfg_req_t      pop_data,
    output logic          full,
    output logic          empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    cfg_req_t      r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    // Blocked operations are dropped here so the caller never corrupts the pointers.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

    // Pointer update; the queue is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    // Payload storage needs no reset: empty is decided by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/pi_cfg_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pi_cfg_writer
//  Description : Queues config-register writes and issues them as PiBus write
//                cycles into the cfg file, optionally reading each one back
//                and retrying on mismatch before flagging an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_cfg_writer
    import pi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 2,
    parameter int VERIFY     = 1,
    parameter int MAX_RETRY  = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pi_cfg_writer_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CFG_AW-1:0] err_addr,
    output logic [7:0]        err_cnt
);

    localparam int c_sc_w = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_rt_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_sc_w-1:0] c_settle_load = c_sc_w'(SETTLE_CYC - 1);
    localparam logic [c_rt_w-1:0] c_max_retry   = c_rt_w'(MAX_RETRY);

    cw_state_t         r_state;
    cw_state_t         w_state_nxt;
    cfg_req_t          r_hold;
    logic [c_sc_w-1:0] r_settle;
    logic [c_rt_w-1:0] r_retry;
    logic [CFG_AW-1:0] r_err_addr;
    logic [7:0]        r_err_cnt;

    logic              w_fifo_pop;
    cfg_req_t          w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_retry_inc;
    logic              w_retry_clr;
    logic              w_err_log;

    cfg_req_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.req_valid),
        .push_data ('{addr: bus.req_addr, data: bus.req_data}),
        .pop       (w_fifo_pop),
        .pop_data  (w_fifo_dout),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // req_ready derives only from FIFO pointer flops, so the full case blocks a push
    // even when the FSM pops in the same cycle.
    assign bus.req_ready = !w_fifo_full;

    // Moore outputs: everything decodes from flops so reset clears them immediately.
    assign bus.pi_act    = (r_state == CW_WRITE);
    assign bus.pi_we     = (r_state == CW_WRITE);
    assign bus.pi_ce_cfg = (r_state == CW_WRITE) || (r_state == CW_SETTLE) ||
                           (r_state == CW_VERIFY);
    assign bus.pi_addr   = r_hold.addr;
    assign bus.pi_dato   = r_hold.data;
    assign busy          = !w_fifo_empty || (r_state != CW_IDLE);
    assign done          = (r_state == CW_DONE) || (r_state == CW_ERR);
    assign err           = (r_state == CW_ERR);
    assign err_addr      = r_err_addr;
    assign err_cnt       = r_err_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CW_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_err_log   = 1'b0;
        case (r_state)
            CW_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = CW_WRITE;
                end
            end
            CW_WRITE:  w_state_nxt = CW_SETTLE;
            CW_SETTLE: begin
                if (r_settle == '0) w_state_nxt = (VERIFY != 0) ? CW_VERIFY : CW_DONE;
            end
            CW_VERIFY: begin
                if (bus.pi_di == r_hold.data) begin
                    w_state_nxt = CW_DONE;
                end else if (r_retry < c_max_retry) begin
                    w_retry_inc = 1'b1;
                    w_state_nxt = CW_WRITE;
                end else begin
                    w_state_nxt = CW_ERR;
                end
            end
            CW_DONE: begin
                w_retry_clr = 1'b1;
                w_state_nxt = CW_IDLE;
            end
            CW_ERR: begin
                w_retry_clr = 1'b1;
                w_err_log   = 1'b1;
                w_state_nxt = CW_IDLE;
            end
            default: w_state_nxt = CW_IDLE;
        endcase
    end

    // Hold registers, settle/retry counters and sticky error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_settle   <= '0;
            r_retry    <= '0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_fifo_pop) r_hold <= w_fifo_dout;

            if (r_state == CW_WRITE) begin
                r_settle <= c_settle_load;
            end else if ((r_state == CW_SETTLE) && (r_settle != '0)) begin
                r_settle <= r_settle - c_sc_w'(1);
            end

            if (w_retry_clr)      r_retry <= '0;
            else if (w_retry_inc) r_retry <= r_retry + c_rt_w'(1);

            if (w_err_log) begin
                r_err_addr <= r_hold.addr;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pi_cfg_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pi_cfg_writer
//  Description : Self-checking bench for pi_cfg_writer with a cfg-file responder
//                model (fault injectable) and a request-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_cfg_writer;
    import pi_pkg::*;

    localparam int SETTLE_CYC = 2;
    localparam int MAX_RETRY  = 2;
    localparam int DEPTH      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    pi_cfg_writer_if ifa ();
    pi_cfg_writer_if ifb ();

    logic       busy_a, done_a, err_a;
    logic [3:0] err_addr_a;
    logic [7:0] err_cnt_a;
    logic       busy_b, done_b, err_b;
    logic [3:0] err_addr_b;
    logic [7:0] err_cnt_b;

    pi_cfg_writer #(
        .FIFO_DEPTH (DEPTH), .SETTLE_CYC (SETTLE_CYC), .VERIFY (1), .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk (clk), .rst_n (rst_n), .bus (ifa), .busy (busy_a), .done (done_a),
        .err (err_a), .err_addr (err_addr_a), .err_cnt (err_cnt_a)
    );

    pi_cfg_writer #(
        .FIFO_DEPTH (DEPTH), .SETTLE_CYC (SETTLE_CYC), .VERIFY (0), .MAX_RETRY (MAX_RETRY)
    ) dut_nv (
        .clk (clk), .rst_n (rst_n), .bus (ifb), .busy (busy_b), .done (done_b),
        .err (err_b), .err_addr (err_addr_b), .err_cnt (err_cnt_b)
    );

    // ---------------- cfg file responder for dut ----------------
    logic [7:0] cfg_a [CFG_REGS] = '{default: 8'h00};
    logic       pend_a      = 1'b0;
    logic [3:0] pend_addr_a = 4'h0;
    logic [7:0] pend_data_a = 8'h00;
    logic       ign_armed   = 1'b0;
    logic       ign_used    = 1'b0;
    logic       stuck_on    = 1'b0;

    // Write enable registered one cycle after act; optionally drops the first write to reg 4.
    always @(posedge clk) begin
        pend_a      <= ifa.pi_act && ifa.pi_we && ifa.pi_ce_cfg;
        pend_addr_a <= ifa.pi_addr;
        pend_data_a <= ifa.pi_dato;
        if (pend_a) begin
            if (ign_armed && !ign_used && pend_addr_a == 4'd4) ign_used <= 1'b1;
            else                                              cfg_a[pend_addr_a] <= pend_data_a;
        end
    end

    assign ifa.pi_di = (stuck_on && ifa.pi_addr == 4'd9) ? 8'h00 : cfg_a[ifa.pi_addr];
    assign ifb.pi_di = 8'h00;

    // ---------------- event monitors ----------------
    typedef struct { logic [3:0] addr; logic [7:0] data; logic we; logic ce; int t; } act_t;
    typedef struct { logic err; int t; } done_t;
    typedef struct { logic [3:0] addr; logic [7:0] data; int n_acts; logic err; } exp_t;

    act_t  act_q[$];
    done_t done_q[$];
    act_t  act_qb[$];
    done_t done_qb[$];
    int    errb_n = 0;

    // Logs act/done pulses tagged with the rising edge that samples them.
    always @(negedge clk) begin
        act_t  a;
        done_t d;
        if (ifa.pi_act) begin
            a.addr = ifa.pi_addr; a.data = ifa.pi_dato; a.we = ifa.pi_we; a.ce = ifa.pi_ce_cfg; a.t = cyc + 1;
            act_q.push_back(a);
        end
        if (done_a) begin
            d.err = err_a; d.t = cyc + 1;
            done_q.push_back(d);
        end
        if (ifb.pi_act) begin
            a.addr = ifb.pi_addr; a.data = ifb.pi_dato; a.we = ifb.pi_we; a.ce = ifb.pi_ce_cfg; a.t = cyc + 1;
            act_qb.push_back(a);
        end
        if (done_b) begin
            d.err = err_b; d.t = cyc + 1;
            done_qb.push_back(d);
        end
        if (err_b) errb_n <= errb_n + 1;
    end

    // ---------------- reference model and checking ----------------
    logic [7:0] model_cfg [CFG_REGS] = '{default: 8'h00};
    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one request on dut; returns the edge that accepted it.
    task automatic push_a(input logic [3:0] a, input logic [7:0] d, output int t_acc);
        ifa.req_valid = 1'b1;
        ifa.req_addr  = a;
        ifa.req_data  = d;
        t_acc = -1;
        for (int k = 0; k < 200; k++) begin
            if (ifa.req_ready) begin
                t_acc = cyc + 1;
                step(1);
                break;
            end
            step(1);
        end
        ifa.req_valid = 1'b0;
        if (t_acc < 0) check("push_timeout", 32'd0, 32'd1);
    endtask

    // Adds a request to the expectation list; a readback failure only affects the verdict.
    task automatic expect_req(input logic [3:0] a, input logic [7:0] d, input int n_acts, input logic e);
        exp_t x;
        x.addr = a; x.data = d; x.n_acts = n_acts; x.err = e;
        exp_q.push_back(x);
        model_cfg[a] = d;
    endtask

    task automatic wait_done_a(input int target, input int budget);
        for (int k = 0; k < budget && done_q.size() < target; k++) step(1);
        step(8);
    endtask

    // Compares the logged act/done pulses since the given bases with exp_q.
    task automatic check_run(input string tag, input int a0, input int d0);
        int ai;
        int tot;
        ai  = a0;
        tot = 0;
        foreach (exp_q[i]) tot += exp_q[i].n_acts;
        check({tag, "_nact"}, act_q.size() - a0, tot);
        check({tag, "_ndone"}, done_q.size() - d0, exp_q.size());
        foreach (exp_q[i]) begin
            for (int j = 0; j < exp_q[i].n_acts; j++) begin
                if (ai < act_q.size()) begin
                    check({tag, "_addr"}, act_q[ai].addr, exp_q[i].addr);
                    check({tag, "_data"}, act_q[ai].data, exp_q[i].data);
                    check({tag, "_we_ce"}, {act_q[ai].we, act_q[ai].ce}, 2'b11);
                    if (ai > a0)
                        check({tag, "_gap"}, (act_q[ai].t - act_q[ai-1].t) >= SETTLE_CYC + 2, 1);
                end
                ai++;
            end
            if (d0 + i < done_q.size()) begin
                check({tag, "_err"}, done_q[d0+i].err, exp_q[i].err);
                if (ai - 1 < act_q.size())
                    check({tag, "_order"}, done_q[d0+i].t > act_q[ai-1].t, 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t_acc;
        int         a0;
        int         d0;
        logic [3:0] ra;
        logic [7:0] rd;

        ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.req_data = '0;
        ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.req_data = '0;

        // Reset state.
        step(3);
        check("rst_ready", ifa.req_ready, 1);
        check("rst_act_we_ce", {ifa.pi_act, ifa.pi_we, ifa.pi_ce_cfg}, 3'b000);
        check("rst_addr_dato", {ifa.pi_addr, ifa.pi_dato}, 12'h000);
        check("rst_status", {busy_a, done_a, err_a}, 3'b000);
        check("rst_err_regs", {err_addr_a, err_cnt_a}, 12'h000);
        rst_n = 1'b1;
        step(2);

        // Single write with latency checks.
        a0 = act_q.size(); d0 = done_q.size(); exp_q.delete();
        push_a(4'd7, 8'h93, t_acc);
        expect_req(4'd7, 8'h93, 1, 1'b0);
        wait_done_a(d0 + 1, 40);
        check_run("t1", a0, d0);
        if (act_q.size() > a0)  check("t1_act_latency", act_q[a0].t - t_acc, 2);
        if (done_q.size() > d0) check("t1_done_latency", done_q[d0].t - t_acc, SETTLE_CYC + 4);
        check("t1_cfg7", cfg_a[7], 8'h93);

        // Five back-to-back requests: only the first can have left the queue.
        a0 = act_q.size(); d0 = done_q.size(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            ra = 4'(i + 1);
            rd = 8'($urandom_range(255, 0));
            push_a(ra, rd, t_acc);
            expect_req(ra, rd, 1, 1'b0);
        end
        check("t2_ready_full", ifa.req_ready, 0);
        check("t2_busy", busy_a, 1);
        wait_done_a(d0 + 5, 200);
        check_run("t2", a0, d0);

        // First write to reg 4 is dropped by the responder: one retry, no error.
        a0 = act_q.size(); d0 = done_q.size(); exp_q.delete();
        ign_armed = 1'b1;
        rd = model_cfg[4] ^ 8'hA5;
        push_a(4'd4, rd, t_acc);
        expect_req(4'd4, rd, 2, 1'b0);
        wait_done_a(d0 + 1, 60);
        check_run("t3", a0, d0);

        // Readback of reg 9 stuck at zero: retries exhausted, error flagged.
        a0 = act_q.size(); d0 = done_q.size(); exp_q.delete();
        stuck_on = 1'b1;
        push_a(4'd9, 8'h5A, t_acc);
        expect_req(4'd9, 8'h5A, MAX_RETRY + 1, 1'b1);
        wait_done_a(d0 + 1, 80);
        check_run("t4", a0, d0);
        check("t4_err_addr", err_addr_a, 4'd9);
        check("t4_err_cnt", err_cnt_a, 8'd1);
        stuck_on = 1'b0;

        // Randomized requests with random idle gaps.
        a0 = act_q.size(); d0 = done_q.size(); exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            ra = 4'($urandom_range(15, 0));
            rd = 8'($urandom_range(255, 0));
            push_a(ra, rd, t_acc);
            expect_req(ra, rd, 1, 1'b0);
            step($urandom_range(3, 0));
        end
        wait_done_a(d0 + 12, 400);
        check_run("rnd", a0, d0);
        check("rnd_err_cnt", err_cnt_a, 8'd1);

        // VERIFY=0 instance: done follows act by SETTLE_CYC+1, readback ignored.
        ifb.req_valid = 1'b1; ifb.req_addr = 4'd0; ifb.req_data = 8'hFF;
        step(1);
        ifb.req_valid = 1'b0;
        for (int k = 0; k < 40 && done_qb.size() < 1; k++) step(1);
        step(8);
        check("t6_nact", act_qb.size(), 1);
        check("t6_ndone", done_qb.size(), 1);
        if (act_qb.size() > 0) check("t6_act_bus", {act_qb[0].addr, act_qb[0].data}, 12'h0FF);
        if (act_qb.size() > 0 && done_qb.size() > 0) begin
            check("t6_done_latency", done_qb[0].t - act_qb[0].t, SETTLE_CYC + 1);
            check("t6_done_err", done_qb[0].err, 0);
        end
        check("t6_err_pulses", errb_n, 0);
        check("t6_busy", busy_b, 0);

        // Asynchronous reset while the first of three requests is settling.
        a0 = act_q.size(); d0 = done_q.size();
        ra = 4'd12;
        rd = model_cfg[12] ^ 8'h3C;
        push_a(ra, rd, t_acc);
        push_a(4'd13, 8'h11, t_acc);
        push_a(4'd14, 8'h22, t_acc);
        model_cfg[ra] = rd;
        for (int k = 0; k < 40 && act_q.size() == a0; k++) step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_act_we_ce", {ifa.pi_act, ifa.pi_we, ifa.pi_ce_cfg}, 3'b000);
        check("t5_addr_dato", {ifa.pi_addr, ifa.pi_dato}, 12'h000);
        check("t5_status", {busy_a, done_a, err_a}, 3'b000);
        check("t5_err_regs", {err_addr_a, err_cnt_a}, 12'h000);
        check("t5_ready", ifa.req_ready, 1);
        step(2);
        rst_n = 1'b1;
        step(30);
        check("t5_nact", act_q.size() - a0, 1);
        check("t5_ndone", done_q.size() - d0, 0);
        check("t5_busy_after", busy_a, 0);

        // Final cfg file contents against the model.
        for (int i = 0; i < CFG_REGS; i++) check($sformatf("cfg_%0d", i), cfg_a[i], model_cfg[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
